// File: rtl/game_pkg.sv
// Shared types and helpers for the memory-sequence game checker.
package game_pkg;
    localparam int STEPS   = 4;
    localparam int STEP_W  = 4;
    localparam int SCORE_W = 3;
    localparam int PAT_W   = STEPS * STEP_W;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SHOW   = 3'd1,
        ST_GAP    = 3'd2,
        ST_INPUT  = 3'd3,
        ST_HOLD   = 3'd4,
        ST_RESULT = 3'd5
    } state_t;

    // Index of the first non-zero step at or after start; 4 means none remain.
    function automatic logic [2:0] first_live(input logic [PAT_W-1:0] pat, input logic [2:0] start);
        logic [2:0] idx;
        idx = 3'd4;
        for (int k = STEPS - 1; k >= 0; k--) begin
            if (k >= int'(start) && pat[STEP_W*k +: STEP_W] != '0) idx = 3'(k);
        end
        return idx;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_score(input logic [3:0] sum);
        return (sum > 4'd4) ? 3'd4 : sum[2:0];
    endfunction
endpackage

// File: rtl/game_tick_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module game_tick_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)             cnt_d = load_val;
        else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/game_seq_checker.sv
// Shows a four-step LED pattern, then checks the player's button presses step by step.
module game_seq_checker
    import game_pkg::*;
#(
    parameter int SHOW_TICKS    = 50_000_000,
    parameter int GAP_TICKS     = 12_500_000,
    parameter int TIMEOUT_TICKS = 250_000_000
) (
    input  logic               osc_clk,
    input  logic               reset_n,
    input  logic               pattern_valid,
    input  logic [PAT_W-1:0]   pattern,
    output logic               pattern_ready,
    input  logic [STEP_W-1:0]  button,
    output logic [STEP_W-1:0]  led,
    output logic               round_done,
    output logic               round_win,
    output logic [SCORE_W-1:0] score
);
    // Interval loads are one less than the length: the load edge counts as the first cycle.
    localparam logic [31:0] SHOW_LOAD = 32'(SHOW_TICKS - 1);
    localparam logic [31:0] GAP_LOAD  = 32'(GAP_TICKS - 1);
    localparam logic [31:0] TO_LOAD   = 32'(TIMEOUT_TICKS - 1);

    state_t              state_q, state_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic [1:0]          step_q, step_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic                win_q, win_d;
    logic                done_q, done_d;
    logic [STEP_W-1:0]   led_q, led_d;
    logic [STEP_W-1:0]   capture_q, capture_d;

    logic                tmr_load, tmr_done;
    logic [31:0]         tmr_val;
    logic [1:0]          step_inc;
    logic [STEP_W-1:0]   nibble;
    logic [2:0]          live_from_zero, live_after_step;

    assign step_inc        = step_q + 2'd1;
    assign nibble          = pat_q[{step_q, 2'b00} +: STEP_W];
    assign live_from_zero  = first_live(pat_q, 3'd0);
    assign live_after_step = first_live(pat_q, {1'b0, step_q} + 3'd1);

    game_tick_timer #(.W(32)) u_timer (
        .clk      (osc_clk),
        .rst      (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        pat_d     = pat_q;
        step_d    = step_q;
        score_d   = score_q;
        win_d     = win_q;
        capture_d = capture_q;
        led_d     = '0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        case (state_q)
            ST_IDLE: begin
                if (pattern_valid) begin
                    pat_d    = pattern;
                    score_d  = '0;
                    win_d    = 1'b0;
                    step_d   = 2'd0;
                    state_d  = ST_SHOW;
                    tmr_load = 1'b1;
                    tmr_val  = SHOW_LOAD;
                    led_d    = pattern[STEP_W-1:0];
                end
            end
            ST_SHOW: begin
                led_d = nibble;
                if (tmr_done) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = GAP_LOAD;
                    led_d    = '0;
                end
            end
            ST_GAP: begin
                if (tmr_done) begin
                    if (step_q == 2'd3) begin
                        // Leading zero steps are credited without waiting for input.
                        score_d = sat_score(4'(score_q) + 4'(live_from_zero));
                        if (live_from_zero == 3'd4) begin
                            state_d = ST_RESULT;
                            win_d   = 1'b1;
                        end else begin
                            state_d  = ST_INPUT;
                            step_d   = live_from_zero[1:0];
                            tmr_load = 1'b1;
                            tmr_val  = TO_LOAD;
                        end
                    end else begin
                        step_d   = step_inc;
                        state_d  = ST_SHOW;
                        tmr_load = 1'b1;
                        tmr_val  = SHOW_LOAD;
                        led_d    = pat_q[{step_inc, 2'b00} +: STEP_W];
                    end
                end
            end
            ST_INPUT: begin
                if (button != '0) begin
                    state_d   = ST_HOLD;
                    capture_d = button;
                    led_d     = button;
                end else if (tmr_done) begin
                    state_d = ST_RESULT;
                    win_d   = 1'b0;
                end
            end
            ST_HOLD: begin
                if (button != '0) begin
                    capture_d = capture_q | button;
                    led_d     = capture_d;
                end else if (capture_q == nibble) begin
                    // Credit this step plus any zero steps that follow it.
                    score_d = sat_score(4'(score_q) + 4'(live_after_step) - 4'(step_q));
                    if (live_after_step == 3'd4) begin
                        state_d = ST_RESULT;
                        win_d   = 1'b1;
                    end else begin
                        state_d  = ST_INPUT;
                        step_d   = live_after_step[1:0];
                        tmr_load = 1'b1;
                        tmr_val  = TO_LOAD;
                    end
                end else begin
                    state_d = ST_RESULT;
                    win_d   = 1'b0;
                end
            end
            ST_RESULT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        done_d = (state_d == ST_RESULT);
    end

    always_ff @(posedge osc_clk) begin
        if (reset_n) begin
            state_q   <= ST_IDLE;
            pat_q     <= '0;
            step_q    <= 2'd0;
            score_q   <= '0;
            win_q     <= 1'b0;
            done_q    <= 1'b0;
            led_q     <= '0;
            capture_q <= '0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            step_q    <= step_d;
            score_q   <= score_d;
            win_q     <= win_d;
            done_q    <= done_d;
            led_q     <= led_d;
            capture_q <= capture_d;
        end
    end

    assign pattern_ready = (state_q == ST_IDLE);
    assign led           = led_q;
    assign round_done    = done_q;
    assign round_win     = win_q;
    assign score         = score_q;
endmodule

// File: doc/game_seq_checker.md
GAME_SEQ_CHECKER -- requirements
Module: game_seq_checker

Interface
REQ-001 SHALL have parameter SHOW_TICKS, default 50_000_000, cycles each step is lit (1 s at 50 MHz).
REQ-002 SHALL have parameter GAP_TICKS, default 12_500_000, dark cycles after each shown step.
REQ-003 SHALL have parameter TIMEOUT_TICKS, default 250_000_000, maximum idle cycles while waiting for a player press.
REQ-004 SHALL have port osc_clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, reset, synchronous and active-high (asserted = 1 despite the name).
REQ-006 SHALL have port pattern_valid, input, 1, upstream pattern generator offers a pattern.
REQ-007 SHALL have port pattern, input, 16, four 4-bit LED steps; step k = pattern[4k+3:4k], step 0 played first.
REQ-008 SHALL have port pattern_ready, output, 1, block can accept a pattern.
REQ-009 SHALL have port button, input, 4, debounced, synchronised level buttons, 1 = pressed.
REQ-010 SHALL have port led, output, 4, registered LED drive.
REQ-011 SHALL have port round_done, output, 1, one-cycle pulse at end of round.
REQ-012 SHALL have port round_win, output, 1, result of last round, held until next accept.
REQ-013 SHALL have port score, output, 3, correct steps in current/last round, 0..4.

Function
REQ-014 FSM states: IDLE, SHOW, GAP, INPUT, HOLD, RESULT.
REQ-015 IDLE: pattern_ready=1, led=0; on pattern_valid&&pattern_ready, latch pattern, clear score/round_win, step=0, go SHOW next cycle.
REQ-016 pattern_ready SHALL be 1 only in IDLE; pattern_valid elsewhere ignored, latched pattern never changes mid-round.
REQ-017 SHOW: led=step nibble for exactly SHOW_TICKS cycles, then GAP with led=0 for exactly GAP_TICKS cycles.
REQ-018 After GAP of step 3, go INPUT with step=0; otherwise step+1 and back to SHOW.
REQ-019 INPUT: led=0; timeout counter runs; first cycle with button!=0 goes HOLD, capture=button.
REQ-020 HOLD: capture |= button each cycle; led=capture (echo); when button==0, compare capture to step nibble.
REQ-021 Match: score+1; if step==3 go RESULT with win=1, else step+1, back to INPUT, timeout cleared.
REQ-022 Mismatch (extra or missing bit): go RESULT with win=0, score unchanged.
REQ-023 Zero step nibble: no input required; counts as correct without entering INPUT for that step.
REQ-024 Timeout: TIMEOUT_TICKS cycles in INPUT with button==0 -> RESULT, win=0. No timeout in HOLD.
REQ-025 RESULT: one cycle; round_done=1, round_win registered; then IDLE.
REQ-026 Buttons already held on INPUT entry SHALL count as a press (level-sensitive, no edge requirement).
REQ-027 score SHALL saturate at 4; no wrap.

Reset
REQ-028 reset_n=1 at any clock edge, including mid-round: state=IDLE, led=0, score=0, round_win=0, round_done=0, counters=0, pattern_ready=1 from the following cycle.
REQ-029 Reset SHALL take priority over pattern_valid and button in the same cycle.

Structure
REQ-030 Package game_pkg SHALL hold the state enum, STEPS=4, STEP_W=4, SCORE_W=3.
REQ-031 One sub-module game_tick_timer (load, count, done), reused for SHOW, GAP and timeout intervals.

Verification (SHOW_TICKS=4, GAP_TICKS=2, TIMEOUT_TICKS=20)
REQ-032 Accept 16'h8421, press 1,2,4,8 correctly -> led shows 1,2,4,8 for 4 cycles each, then round_done pulse, round_win=1, score=4.
REQ-033 Accept 16'h3321, press 1 then 4 -> round_done, round_win=0, score=1.
REQ-034 Accept 16'h0F0F, press F, then press F -> zero steps skipped, round_win=1, score=4.
REQ-035 Accept pattern, no press for 20 cycles in INPUT -> round_done, round_win=0, score=0.
REQ-036 Press 3 built as 1 then 1|2 before release on step 4'h3 -> match; pattern_valid held through round -> pattern_ready=0, no reload.
REQ-037 reset_n pulse during SHOW -> next cycle led=0, pattern_ready=1, score=0, no round_done pulse.
